uart_rx_packet_parser: RTL and testbench

//  Downstream of the UART IP output port (so/ro/dout). Consumes received bytes, drops in-band
//  XON/XOFF characters, and removes escape bytes. Parses frames of the form
//  SOF(0x7E) | LEN | PAYLOAD[LEN] | CSUM and streams payload bytes out over valid/ready.

---
 rtl/uart_rx_packet_parser.sv | 201 ++++++++++++++++++++
 tb/tb_uart_rx_packet_parser.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_packet_parser.sv
// ============================================================================
// Module  : uart_rx_packet_parser
// Brief   : Byte-stream framer behind a UART receiver. It strips XON/XOFF and
//           escape bytes, parses SOF|LEN|PAYLOAD|CSUM frames and streams the
//           payload out over valid/ready with per-frame status and counters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_packet_parser #(
  parameter int FRAME_WIDTH    = 8,
  parameter int MAX_LEN        = 64,
  parameter int TIMEOUT_CYCLES = 40000
) (
  input  logic                   sys_clk,
  input  logic                   reset,
  input  logic [0:FRAME_WIDTH-1] rx_data,
  input  logic                   rx_send,
  output logic                   rx_ready,
  output logic [0:FRAME_WIDTH-1] pkt_data,
  output logic                   pkt_valid,
  input  logic                   pkt_ready,
  output logic                   pkt_last,
  output logic                   pkt_done,
  output logic                   pkt_ok,
  output logic [1:0]             pkt_err,
  output logic [15:0]            good_cnt,
  output logic [15:0]            bad_cnt
);

  localparam int                   IDLE_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [FRAME_WIDTH-1:0] C_SOF   = FRAME_WIDTH'(8'h7E);
  localparam logic [FRAME_WIDTH-1:0] C_ESC   = FRAME_WIDTH'(8'h7D);
  localparam logic [FRAME_WIDTH-1:0] C_XON   = FRAME_WIDTH'(8'h11);
  localparam logic [FRAME_WIDTH-1:0] C_XOFF  = FRAME_WIDTH'(8'h13);
  localparam logic [FRAME_WIDTH-1:0] C_FLIP  = FRAME_WIDTH'(8'h20);
  localparam logic [FRAME_WIDTH-1:0] C_MAXL  = FRAME_WIDTH'(MAX_LEN);
  localparam logic [IDLE_W-1:0]      C_IDLE  = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0]            C_SAT   = 16'hFFFF;

  typedef enum logic [1:0] {
    S_HUNT    = 2'd0,
    S_LEN     = 2'd1,
    S_PAYLOAD = 2'd2,
    S_CSUM    = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic                     esc_q, esc_d;
  logic [FRAME_WIDTH-1:0]   len_q, len_d;
  logic [FRAME_WIDTH-1:0]   sum_q, sum_d;
  logic [IDLE_W-1:0]        idle_q, idle_d;
  logic [FRAME_WIDTH-1:0]   pkt_data_q, pkt_data_d;
  logic                     pkt_valid_q, pkt_valid_d;
  logic                     pkt_last_q, pkt_last_d;
  logic                     pkt_done_q, pkt_done_d;
  logic                     pkt_ok_q, pkt_ok_d;
  logic [1:0]               pkt_err_q, pkt_err_d;
  logic [15:0]              good_cnt_q, good_cnt_d;
  logic [15:0]              bad_cnt_q, bad_cnt_d;
  logic                     rx_ready_q, rx_ready_d;

  logic                     consume;
  logic [FRAME_WIDTH-1:0]   raw;
  logic [FRAME_WIDTH-1:0]   val;
  logic [FRAME_WIDTH-1:0]   sum_chk;
  logic                     is_flow, is_esc, is_sof, byte_v;
  logic                     good_inc, bad_inc;

  assign consume = rx_send & rx_ready_q;
  assign raw     = rx_data;
  assign is_flow = (raw == C_XON) || (raw == C_XOFF);
  assign is_esc  = (raw == C_ESC);
  // SOF is recognised on the raw byte, so an escaped 0x7E still resyncs
  assign is_sof  = (raw == C_SOF);
  assign byte_v  = consume & ~is_flow & ~is_esc;
  assign val     = esc_q ? (raw ^ C_FLIP) : raw;
  assign sum_chk = sum_q + val;

  always_comb begin
    state_d     = state_q;
    esc_d       = esc_q;
    len_d       = len_q;
    sum_d       = sum_q;
    pkt_data_d  = pkt_data_q;
    pkt_valid_d = pkt_valid_q;
    pkt_last_d  = pkt_last_q;
    pkt_done_d  = 1'b0;
    pkt_ok_d    = 1'b0;
    pkt_err_d   = pkt_err_q;
    good_inc    = 1'b0;
    bad_inc     = 1'b0;
    idle_d      = (state_q == S_HUNT || consume) ? '0 : idle_q + 1'b1;

    if (consume && !is_flow) esc_d = is_esc;
    if (pkt_valid_q && pkt_ready) pkt_valid_d = 1'b0;

    if (byte_v && is_sof && state_q != S_HUNT) begin
      pkt_done_d = 1'b1;
      pkt_err_d  = 2'd3;
      bad_inc    = 1'b1;
      state_d    = S_LEN;
    end else if (byte_v) begin
      case (state_q)
        S_HUNT: if (is_sof) state_d = S_LEN;
        S_LEN: begin
          len_d = val;
          sum_d = val;
          if (val > C_MAXL) begin
            pkt_done_d = 1'b1;
            pkt_err_d  = 2'd2;
            bad_inc    = 1'b1;
            state_d    = S_HUNT;
          end else if (val == '0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          pkt_data_d  = val;
          pkt_valid_d = 1'b1;
          pkt_last_d  = (len_q == FRAME_WIDTH'(1));
          sum_d       = sum_chk;
          len_d       = len_q - 1'b1;
          if (len_q == FRAME_WIDTH'(1)) state_d = S_CSUM;
        end
        S_CSUM: begin
          pkt_done_d = 1'b1;
          if (sum_chk == '0) begin
            pkt_ok_d  = 1'b1;
            pkt_err_d = 2'd0;
            good_inc  = 1'b1;
          end else begin
            pkt_err_d = 2'd1;
            bad_inc   = 1'b1;
          end
          state_d = S_HUNT;
        end
        default: state_d = S_HUNT;
      endcase
    end else if (state_q != S_HUNT && !consume && idle_q == C_IDLE) begin
      pkt_done_d = 1'b1;
      pkt_err_d  = 2'd3;
      bad_inc    = 1'b1;
      state_d    = S_HUNT;
    end

    good_cnt_d = (good_inc && good_cnt_q != C_SAT) ? good_cnt_q + 1'b1 : good_cnt_q;
    bad_cnt_d  = (bad_inc && bad_cnt_q != C_SAT) ? bad_cnt_q + 1'b1 : bad_cnt_q;
    // Holding off the UART while a payload byte waits keeps one byte in flight
    rx_ready_d = ~pkt_valid_d;
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_HUNT;
      esc_q       <= 1'b0;
      len_q       <= '0;
      sum_q       <= '0;
      idle_q      <= '0;
      pkt_data_q  <= '0;
      pkt_valid_q <= 1'b0;
      pkt_last_q  <= 1'b0;
      pkt_done_q  <= 1'b0;
      pkt_ok_q    <= 1'b0;
      pkt_err_q   <= 2'd0;
      good_cnt_q  <= '0;
      bad_cnt_q   <= '0;
      rx_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      esc_q       <= esc_d;
      len_q       <= len_d;
      sum_q       <= sum_d;
      idle_q      <= idle_d;
      pkt_data_q  <= pkt_data_d;
      pkt_valid_q <= pkt_valid_d;
      pkt_last_q  <= pkt_last_d;
      pkt_done_q  <= pkt_done_d;
      pkt_ok_q    <= pkt_ok_d;
      pkt_err_q   <= pkt_err_d;
      good_cnt_q  <= good_cnt_d;
      bad_cnt_q   <= bad_cnt_d;
      rx_ready_q  <= rx_ready_d;
    end
  end

  assign rx_ready  = rx_ready_q;
  assign pkt_data  = pkt_data_q;
  assign pkt_valid = pkt_valid_q;
  assign pkt_last  = pkt_last_q;
  assign pkt_done  = pkt_done_q;
  assign pkt_ok    = pkt_ok_q;
  assign pkt_err   = pkt_err_q;
  assign good_cnt  = good_cnt_q;
  assign bad_cnt   = bad_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_packet_parser.sv
// ============================================================================
// Module  : tb_uart_rx_packet_parser
// Brief   : Directed, table-driven bench for uart_rx_packet_parser.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_packet_parser;

  localparam int TO = 40000;

  logic        sys_clk = 1'b0;
  logic        reset   = 1'b1;
  logic [0:7]  rx_data = '0;
  logic        rx_send = 1'b0;
  logic        rx_ready;
  logic [0:7]  pkt_data;
  logic        pkt_valid;
  logic        pkt_ready = 1'b1;
  logic        pkt_last;
  logic        pkt_done;
  logic        pkt_ok;
  logic [1:0]  pkt_err;
  logic [15:0] good_cnt;
  logic [15:0] bad_cnt;

  uart_rx_packet_parser #(
    .FRAME_WIDTH    (8),
    .MAX_LEN        (64),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_send   (rx_send),
    .rx_ready  (rx_ready),
    .pkt_data  (pkt_data),
    .pkt_valid (pkt_valid),
    .pkt_ready (pkt_ready),
    .pkt_last  (pkt_last),
    .pkt_done  (pkt_done),
    .pkt_ok    (pkt_ok),
    .pkt_err   (pkt_err),
    .good_cnt  (good_cnt),
    .bad_cnt   (bad_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct packed {
    logic       ok;
    logic [1:0] err;
    int         at;
  } done_t;

  logic [8:0] pay_q[$];
  done_t      done_q[$];

  always @(negedge sys_clk) begin
    if (pkt_valid && pkt_ready) pay_q.push_back({pkt_last, pkt_data});
    if (pkt_done) done_q.push_back('{ok: pkt_ok, err: pkt_err, at: cyc});
  end

  int n_checks = 0;
  int n_fail   = 0;
  int last_cons = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge sys_clk);
    rx_data = b;
    rx_send = 1'b1;
    while (!rx_ready && n < 200) begin
      @(negedge sys_clk);
      n++;
    end
    check("send_timeout", (n >= 200), 1'b0);
    @(posedge sys_clk);
    #1;
    last_cons = cyc;
    rx_send = 1'b0;
  endtask

  typedef struct packed {
    int              nb;
    logic [0:7][7:0] b;
    int              np;
    logic [0:3][7:0] p;
    int              nd;
    logic            ok;
    logic [1:0]      err;
    int              good;
    int              bad;
  } vec_t;

  vec_t vecs[5];
  logic [7:0] t1_bytes[6] = '{8'h7E, 8'h03, 8'hA1, 8'hB2, 8'hC3, 8'hE7};

  initial begin
    logic [7:0] d0;
    logic       stable;
    logic [7:0] t5[7];
    logic [7:0] fr[4];

    vecs[0] = '{nb: 6, b: {8'h7E, 8'h03, 8'hA1, 8'hB2, 8'hC3, 8'hE7, 8'h00, 8'h00},
                np: 3, p: {8'hA1, 8'hB2, 8'hC3, 8'h00}, nd: 1, ok: 1'b1, err: 2'd0, good: 1, bad: 0};
    vecs[1] = '{nb: 6, b: {8'h7E, 8'h01, 8'h7D, 8'h11, 8'h5E, 8'h81, 8'h00, 8'h00},
                np: 1, p: {8'h7E, 8'h00, 8'h00, 8'h00}, nd: 1, ok: 1'b1, err: 2'd0, good: 2, bad: 0};
    vecs[2] = '{nb: 5, b: {8'h7E, 8'h02, 8'h10, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00},
                np: 2, p: {8'h10, 8'h20, 8'h00, 8'h00}, nd: 1, ok: 1'b0, err: 2'd1, good: 2, bad: 1};
    vecs[3] = '{nb: 2, b: {8'h7E, 8'h50, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                np: 0, p: '0, nd: 1, ok: 1'b0, err: 2'd2, good: 2, bad: 2};
    vecs[4] = '{nb: 3, b: {8'h7E, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                np: 0, p: '0, nd: 1, ok: 1'b1, err: 2'd0, good: 3, bad: 2};

    // Reset state
    repeat (3) @(negedge sys_clk);
    check("reset_ctrl", {rx_ready, pkt_valid, pkt_last, pkt_done, pkt_ok, pkt_err}, '0);
    check("reset_data", pkt_data, '0);
    check("reset_cnts", {good_cnt, bad_cnt}, '0);
    reset = 1'b0;
    @(negedge sys_clk);
    check("rx_ready_after_reset", rx_ready, 1'b1);

    for (int v = 0; v < 5; v++) begin
      pay_q.delete();
      done_q.delete();
      for (int i = 0; i < vecs[v].nb; i++) send_byte(vecs[v].b[i]);
      repeat (6) @(negedge sys_clk);
      check($sformatf("v%0d_npay", v), pay_q.size(), vecs[v].np);
      for (int i = 0; i < vecs[v].np && i < pay_q.size(); i++)
        check($sformatf("v%0d_pay%0d", v, i), pay_q[i], {(i == vecs[v].np - 1), vecs[v].p[i]});
      check($sformatf("v%0d_ndone", v), done_q.size(), vecs[v].nd);
      if (done_q.size() > 0)
        check($sformatf("v%0d_status", v), {done_q[0].ok, done_q[0].err}, {vecs[v].ok, vecs[v].err});
      check($sformatf("v%0d_err_held", v), pkt_err, vecs[v].err);
      check($sformatf("v%0d_cnts", v), {good_cnt, bad_cnt}, {16'(vecs[v].good), 16'(vecs[v].bad)});
    end

    // Resync on SOF mid-payload; the partial byte already delivered stays delivered
    t5 = '{8'h7E, 8'h04, 8'hAA, 8'h7E, 8'h01, 8'h55, 8'hAA};
    pay_q.delete();
    done_q.delete();
    for (int i = 0; i < 7; i++) send_byte(t5[i]);
    repeat (6) @(negedge sys_clk);
    check("t5_ndone", done_q.size(), 2);
    if (done_q.size() == 2) begin
      check("t5_abort", {done_q[0].ok, done_q[0].err}, {1'b0, 2'd3});
      check("t5_ok", {done_q[1].ok, done_q[1].err}, {1'b1, 2'd0});
    end
    check("t5_npay", pay_q.size(), 2);
    if (pay_q.size() == 2) check("t5_pay", {pay_q[0], pay_q[1]}, {1'b0, 8'hAA, 1'b1, 8'h55});
    check("t5_cnts", {good_cnt, bad_cnt}, {16'd4, 16'd3});

    // Backpressure: first payload byte held for 20 cycles
    pay_q.delete();
    done_q.delete();
    pkt_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) send_byte(t1_bytes[i]);
      end
    join_none
    for (int i = 0; i < 200 && !pkt_valid; i++) @(negedge sys_clk);
    check("bp_valid_seen", pkt_valid, 1'b1);
    d0 = pkt_data;
    stable = 1'b1;
    repeat (20) begin
      @(negedge sys_clk);
      if (rx_ready || !pkt_valid || pkt_data !== d0 || pkt_last) stable = 1'b0;
    end
    check("bp_stable", stable, 1'b1);
    check("bp_first", d0, 8'hA1);
    @(posedge sys_clk);
    #1 pkt_ready = 1'b1;
    wait fork;
    repeat (6) @(negedge sys_clk);
    check("bp_npay", pay_q.size(), 3);
    if (pay_q.size() == 3) check("bp_pay", {pay_q[0], pay_q[1], pay_q[2]},
                                 {1'b0, 8'hA1, 1'b0, 8'hB2, 1'b1, 8'hC3});
    check("bp_status", (done_q.size() == 1) ? {done_q[0].ok, done_q[0].err} : 3'b111, {1'b1, 2'd0});
    check("bp_cnts", {good_cnt, bad_cnt}, {16'd5, 16'd3});

    // Inter-byte timeout, measured from the consumed XON byte
    pay_q.delete();
    done_q.delete();
    send_byte(8'h7E);
    send_byte(8'h02);
    send_byte(8'h11);
    for (int i = 0; i < TO + 20 && done_q.size() == 0; i++) @(negedge sys_clk);
    check("to_ndone", done_q.size(), 1);
    if (done_q.size() == 1) begin
      check("to_delay", done_q[0].at - last_cons, TO);
      check("to_status", {done_q[0].ok, done_q[0].err}, {1'b0, 2'd3});
    end
    check("to_npay", pay_q.size(), 0);
    check("to_cnts", {good_cnt, bad_cnt}, {16'd5, 16'd4});

    // Reset mid-frame with an escape pending
    done_q.delete();
    send_byte(8'h7E);
    send_byte(8'h03);
    send_byte(8'hA1);
    send_byte(8'h7D);
    @(negedge sys_clk);
    reset = 1'b1;
    #1;
    check("rst_mid_ctrl", {rx_ready, pkt_valid, pkt_last, pkt_done, pkt_ok, pkt_err}, '0);
    check("rst_mid_cnts", {good_cnt, bad_cnt}, '0);
    repeat (3) @(negedge sys_clk);
    reset = 1'b0;
    repeat (2) @(negedge sys_clk);
    check("rst_mid_nodone", done_q.size(), 0);
    pay_q.delete();
    fr = '{8'h7E, 8'h01, 8'h5E, 8'hA1};
    for (int i = 0; i < 4; i++) send_byte(fr[i]);
    repeat (6) @(negedge sys_clk);
    check("post_rst_pay", (pay_q.size() == 1) ? pay_q[0] : 9'h000, {1'b1, 8'h5E});
    check("post_rst_status", (done_q.size() == 1) ? {done_q[0].ok, done_q[0].err} : 3'b111, {1'b1, 2'd0});
    check("post_rst_cnts", {good_cnt, bad_cnt}, {16'd1, 16'd0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
